// File: rtl/mul_pipe.sv
`default_nettype none
// ============================================================================
// Module   : mul_pipe
// Purpose  : Pipelined multiplier with valid/ready flow control, per-sample
//            signed/unsigned mode, rounded right-shift scaling, narrowing to
//            O_W bits and overflow detection.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   A_W, B_W    operand widths
//   O_W         output width (must not exceed A_W+B_W)
//   STAGES      register stages (>= 1), equals latency in clock edges
//   SHIFT       rounding right shift applied before narrowing
// Ports
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   in_valid    operands present             in_ready   operands accepted
//   a, b        operands                     signed_mode 1 = two's complement
//   out_valid   result present               out_ready  downstream accepts
//   mul_out     scaled, narrowed product     ovf        result did not fit
// Build option
//   MUL_SAT_EN  defined: clamp mul_out on overflow; undefined: wrap.
// ============================================================================
module mul_pipe #(
  parameter int A_W    = 6,
  parameter int B_W    = 6,
  parameter int O_W    = 6,
  parameter int STAGES = 2,
  parameter int SHIFT  = 0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [A_W-1:0] a,
  input  logic [B_W-1:0] b,
  input  logic           signed_mode,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [O_W-1:0] mul_out,
  output logic           ovf
);

  // Product width and working width. Two guard bits keep the unsigned
  // product positive when viewed as signed and leave room for the rounding
  // add, so one signed datapath serves both modes.
  localparam int c_PW = A_W + B_W;
  localparam int c_RW = c_PW + 2;

  localparam logic signed [c_RW-1:0] c_SMAX = c_RW'((longint'(1) << (O_W - 1)) - 1);
  localparam logic signed [c_RW-1:0] c_SMIN = c_RW'(-(longint'(1) << (O_W - 1)));
  localparam logic signed [c_RW-1:0] c_UMAX = c_RW'((longint'(1) << O_W) - 1);

  // Global advance: the whole pipe moves when the output slot is empty or
  // being consumed this cycle.
  logic w_en;

  // Operands as seen by the final (result) stage.
  logic           w_fv;
  logic [A_W-1:0] w_fa;
  logic [B_W-1:0] w_fb;
  logic           w_fsm;

  logic                   r_out_valid;
  logic [O_W-1:0]         r_mul_out;
  logic                   r_ovf;

  logic signed [c_RW-1:0] w_ax;
  logic signed [c_RW-1:0] w_bx;
  logic signed [c_RW-1:0] w_p;
  logic signed [c_RW-1:0] w_r;
  logic                   w_fit;
  logic [O_W-1:0]         w_nar;

  assign w_en      = out_ready | ~r_out_valid;
  assign in_ready  = w_en;
  assign out_valid = r_out_valid;
  assign mul_out   = r_mul_out;
  assign ovf       = r_ovf;

  // --------------------------------------------------------------------------
  // Operand delay stages (all but the last register stage). With a single
  // stage the result register samples the inputs directly.
  // --------------------------------------------------------------------------
  generate
    if (STAGES > 1) begin : g_front
      localparam int c_NF = STAGES - 1;

      logic           r_vld [c_NF];
      logic [A_W-1:0] r_a   [c_NF];
      logic [B_W-1:0] r_b   [c_NF];
      logic           r_sm  [c_NF];

      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < c_NF; i++) begin
            r_vld[i] <= 1'b0;
            r_a[i]   <= '0;
            r_b[i]   <= '0;
            r_sm[i]  <= 1'b0;
          end
        end else if (w_en) begin
          r_vld[0] <= in_valid;
          r_a[0]   <= a;
          r_b[0]   <= b;
          r_sm[0]  <= signed_mode;
          for (int i = 1; i < c_NF; i++) begin
            r_vld[i] <= r_vld[i-1];
            r_a[i]   <= r_a[i-1];
            r_b[i]   <= r_b[i-1];
            r_sm[i]  <= r_sm[i-1];
          end
        end
      end

      assign w_fv  = r_vld[c_NF-1];
      assign w_fa  = r_a[c_NF-1];
      assign w_fb  = r_b[c_NF-1];
      assign w_fsm = r_sm[c_NF-1];
    end else begin : g_direct
      assign w_fv  = in_valid;
      assign w_fa  = a;
      assign w_fb  = b;
      assign w_fsm = signed_mode;
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Exact product. Operands are sign- or zero-extended to the working width;
  // the true product always fits there, so the truncated signed multiply is
  // exact for both modes.
  // --------------------------------------------------------------------------
  always_comb begin
    w_ax = {{(c_RW - A_W){w_fsm & w_fa[A_W-1]}}, w_fa};
    w_bx = {{(c_RW - B_W){w_fsm & w_fb[B_W-1]}}, w_fb};
    w_p  = w_ax * w_bx;
  end

  // --------------------------------------------------------------------------
  // Round-half-up scaling. An unsigned product is non-negative here, so the
  // arithmetic shift behaves as a logical shift in that mode.
  // --------------------------------------------------------------------------
  generate
    if (SHIFT == 0) begin : g_noshift
      assign w_r = w_p;
    end else begin : g_shift
      localparam logic signed [c_RW-1:0] c_HALF =
        {{(c_RW - 1){1'b0}}, 1'b1} << (SHIFT - 1);
      assign w_r = (w_p + c_HALF) >>> SHIFT;
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Fit check and narrowing.
  // --------------------------------------------------------------------------
  always_comb begin
    if (w_fsm) begin
      w_fit = (w_r >= c_SMIN) && (w_r <= c_SMAX);
    end else begin
      w_fit = (w_r <= c_UMAX);
    end
  end

`ifdef MUL_SAT_EN
  always_comb begin
    w_nar = w_r[O_W-1:0];
    if (!w_fit) begin
      if (w_fsm) begin
        // Clamp toward the sign of the scaled result.
        w_nar = w_r[c_RW-1] ? c_SMIN[O_W-1:0] : c_SMAX[O_W-1:0];
      end else begin
        w_nar = c_UMAX[O_W-1:0];
      end
    end
  end
`else
  always_comb begin
    w_nar = w_r[O_W-1:0];
  end
`endif

  // --------------------------------------------------------------------------
  // Result stage. ovf is masked by the valid bit so bubbles never flag.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_mul_out   <= '0;
      r_ovf       <= 1'b0;
    end else if (w_en) begin
      r_out_valid <= w_fv;
      r_mul_out   <= w_nar;
      r_ovf       <= w_fv & ~w_fit;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mul_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_mul_pipe
// Purpose  : Scoreboard testbench for mul_pipe. Instance 0 uses default
//            parameters (SHIFT=0), instance 1 uses SHIFT=2. Expected results
//            are queued at acceptance and popped by per-instance monitors.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mul_pipe;

`ifdef MUL_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       iv0, ir0, sm0, ov0, or0, of0;
  logic [5:0] a0, b0, mo0;
  logic       iv1, ir1, sm1, ov1, or1, of1;
  logic [5:0] a1, b1, mo1;

  int checks   = 0;
  int failures = 0;

  logic [6:0] q0[$];
  logic [6:0] q1[$];

  mul_pipe #(.A_W(6), .B_W(6), .O_W(6), .STAGES(2), .SHIFT(0)) u_dut0 (
    .clk(clk), .rst(rst), .in_valid(iv0), .in_ready(ir0), .a(a0), .b(b0),
    .signed_mode(sm0), .out_valid(ov0), .out_ready(or0), .mul_out(mo0), .ovf(of0)
  );

  mul_pipe #(.A_W(6), .B_W(6), .O_W(6), .STAGES(2), .SHIFT(2)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1),
    .signed_mode(sm1), .out_valid(ov1), .out_ready(or1), .mul_out(mo1), .ovf(of1)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Monitors: sample at negedge+2, after every driver has settled for the
  // upcoming rising edge.
  always begin : mon0
    logic [6:0] e;
    @(negedge clk);
    #2;
    if (!rst && ov0 && or0) begin
      if (q0.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL dut0_spurious: got output %0d, expected none", mo0);
      end else begin
        e = q0.pop_front();
        chk("dut0_mul_out", 32'(mo0), 32'(e[5:0]));
        chk("dut0_ovf", 32'(of0), 32'(e[6]));
      end
    end
  end

  always begin : mon1
    logic [6:0] e;
    @(negedge clk);
    #2;
    if (!rst && ov1 && or1) begin
      if (q1.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL dut1_spurious: got output %0d, expected none", mo1);
      end else begin
        e = q1.pop_front();
        chk("dut1_mul_out", 32'(mo1), 32'(e[5:0]));
        chk("dut1_ovf", 32'(of1), 32'(e[6]));
      end
    end
  end

  // Present one sample and hold it until accepted; returns just after the
  // accepting rising edge with in_valid still asserted.
  task automatic send(input int sel, input logic [5:0] ta, input logic [5:0] tb,
                      input logic tsm, input logic [5:0] eo, input logic eovf);
    int  n    = 0;
    bit  done = 1'b0;
    @(negedge clk);
    if (sel == 0) begin a0 = ta; b0 = tb; sm0 = tsm; iv0 = 1'b1; end
    else          begin a1 = ta; b1 = tb; sm1 = tsm; iv1 = 1'b1; end
    while (!done) begin
      #2;
      if ((sel == 0) ? ir0 : ir1) begin
        if (sel == 0) q0.push_back({eovf, eo});
        else          q1.push_back({eovf, eo});
        done = 1'b1;
        @(posedge clk);
      end else begin
        n++;
        if (n > 50) begin
          checks++;
          failures++;
          $display("FAIL send_timeout: in_ready stayed 0, expected 1 within 50 cycles");
          done = 1'b1;
        end else begin
          @(negedge clk);
        end
      end
    end
  endtask

  task automatic drain(input int sel);
    int n = 0;
    while (((sel == 0) ? q0.size() : q1.size()) != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    if (((sel == 0) ? q0.size() : q1.size()) != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout: %0d results pending, expected 0",
               (sel == 0) ? q0.size() : q1.size());
    end
  endtask

  initial begin
    rst = 1'b1;
    iv0 = 1'b0; a0 = '0; b0 = '0; sm0 = 1'b0; or0 = 1'b1;
    iv1 = 1'b0; a1 = '0; b1 = '0; sm1 = 1'b0; or1 = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #2;
    chk("reset_out_valid", 32'(ov0), 32'd0);
    chk("reset_mul_out", 32'(mo0), 32'd0);
    chk("reset_ovf", 32'(of0), 32'd0);
    chk("reset_in_ready", 32'(ir0), 32'd1);

    // Latency: result appears after the second edge following acceptance.
    send(0, 6'd5, 6'd6, 1'b0, 6'd30, 1'b0);
    @(negedge clk);
    iv0 = 1'b0;
    #2;
    chk("latency_edge1_valid", 32'(ov0), 32'd0);
    @(negedge clk);
    #2;
    chk("latency_edge2_valid", 32'(ov0), 32'd1);

    // Directed vectors, SHIFT=0, back-to-back.
    send(0, 6'h3D, 6'd7,  1'b1, 6'd43, 1'b0);                 // -3*7 = -21
    send(0, 6'd61, 6'd7,  1'b0, SAT ? 6'd63 : 6'd43, 1'b1);   // 427
    send(0, 6'd63, 6'd63, 1'b0, SAT ? 6'd63 : 6'd1, 1'b1);    // 3969
    send(0, 6'h20, 6'h20, 1'b1, SAT ? 6'd31 : 6'd0, 1'b1);    // -32*-32 = 1024
    send(0, 6'd7,  6'h3C, 1'b1, 6'd36, 1'b0);                 // 7*-4 = -28
    send(0, 6'h20, 6'd1,  1'b1, 6'd32, 1'b0);                 // -32 fits
    send(0, 6'd4,  6'd8,  1'b1, SAT ? 6'd31 : 6'd32, 1'b1);   // +32 does not
    send(0, 6'd1,  6'd63, 1'b0, 6'd63, 1'b0);                 // 63 fits
    send(0, 6'd8,  6'd8,  1'b0, SAT ? 6'd63 : 6'd0, 1'b1);    // 64 does not
    @(negedge clk);
    iv0 = 1'b0;
    drain(0);

    // SHIFT=2 instance.
    send(1, 6'd5,  6'd3,  1'b0, 6'd4,  1'b0);                 // (15+2)>>2 = 4
    send(1, 6'h3D, 6'd3,  1'b1, 6'd62, 1'b0);                 // (-9+2)>>>2 = -2
    send(1, 6'h3D, 6'd1,  1'b1, 6'd63, 1'b0);                 // (-3+2)>>>2 = -1
    send(1, 6'd63, 6'd63, 1'b0, SAT ? 6'd63 : 6'd32, 1'b1);   // 3971>>2 = 992
    send(1, 6'd6,  6'd42, 1'b0, 6'd63, 1'b0);                 // 254>>2 = 63
    send(1, 6'd6,  6'd43, 1'b0, SAT ? 6'd63 : 6'd1, 1'b1);    // 260>>2 = 65
    @(negedge clk);
    iv1 = 1'b0;
    drain(1);

    // Backpressure: stall 4 cycles after the first result appears.
    fork
      begin
        for (int i = 1; i <= 4; i++) send(0, 6'(i), 6'(i), 1'b0, 6'(i * i), 1'b0);
        @(negedge clk);
        iv0 = 1'b0;
      end
      begin
        int  n    = 0;
        bit  seen = 1'b0;
        while (!seen && n < 20) begin
          @(negedge clk);
          #1;
          if (ov0) seen = 1'b1;
          else     n++;
        end
        if (!seen) begin
          checks++;
          failures++;
          $display("FAIL bp_first_valid: out_valid stayed 0, expected 1 within 20 cycles");
        end else begin
          or0 = 1'b0;
          for (int k = 0; k < 4; k++) begin
            #2;
            chk("bp_stall_in_ready", 32'(ir0), 32'd0);
            chk("bp_stall_valid", 32'(ov0), 32'd1);
            chk("bp_stall_mul_out", 32'(mo0), 32'd1);
            @(negedge clk);
            #1;
          end
          or0 = 1'b1;
          for (int k = 0; k < 4; k++) begin
            #2;
            chk("bp_release_no_gap", 32'(ov0), 32'd1);
            @(negedge clk);
            #1;
          end
        end
      end
    join
    drain(0);

    // Reset with two samples in flight (held by backpressure).
    @(negedge clk);
    or0 = 1'b0;
    send(0, 6'd7, 6'd7, 1'b0, 6'd49, 1'b0);
    send(0, 6'd3, 6'd3, 1'b0, 6'd9, 1'b0);
    @(negedge clk);
    iv0 = 1'b0;
    #1;
    chk("inflight_held_valid", 32'(ov0), 32'd1);
    rst = 1'b1;
    q0.delete();
    @(negedge clk);
    rst = 1'b0;
    or0 = 1'b1;
    #2;
    chk("midreset_out_valid", 32'(ov0), 32'd0);
    chk("midreset_mul_out", 32'(mo0), 32'd0);
    chk("midreset_ovf", 32'(of0), 32'd0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      #2;
      chk("midreset_no_stale", 32'(ov0), 32'd0);
    end
    send(0, 6'd2, 6'd3, 1'b0, 6'd6, 1'b0);
    @(negedge clk);
    iv0 = 1'b0;
    #2;
    chk("post_reset_edge1_valid", 32'(ov0), 32'd0);
    @(negedge clk);
    #2;
    chk("post_reset_edge2_valid", 32'(ov0), 32'd1);
    drain(0);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
